// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/mem/writeback sequencer for the
// multi-cycle RV32I core. One shared memory port, timeout trap, illegal-opcode trap.
//
// state  | meaning
// FETCH  | request instruction word at PC, latch into IR on mem_ready
// DECODE | classify opcode; FENCE retires here, illegal opcodes trap
// EXEC   | ALU operation; branches and jumps retire here
// MEM    | data load/store at ALU result address
// WB     | register-file write, PC advance
// TRAP   | halted until reset
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_fmt,
  output logic        trap,
  output logic        trap_cause
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
    C_OPIMM, C_OP, C_FENCE, C_ILL
  } cls_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW:0]   w_cnt_inc;
  logic          w_timeout;
  logic          r_trap;
  logic          r_trap_cause;
  logic          w_cause;
  cls_t          w_cls;
  logic          w_a_sel;
  logic          w_b_sel;
  logic [1:0]    w_op;
  logic [2:0]    w_fmt;
  logic          w_unused_instr;

  // only the opcode field steers the sequencer
  assign w_unused_instr = ^instr[31:7];

  assign w_cnt_inc = {1'b0, r_cnt} + (CW + 1)'(1);
  assign w_timeout = (MEM_TIMEOUT != 0) && (w_cnt_inc == (CW + 1)'(MEM_TIMEOUT));

  // opcode classification
  always_comb begin
    w_cls = C_ILL;
    case (instr[6:0])
      7'b0110111: w_cls = C_LUI;
      7'b0010111: w_cls = C_AUIPC;
      7'b1101111: w_cls = C_JAL;
      7'b1100111: w_cls = C_JALR;
      7'b1100011: w_cls = C_BRANCH;
      7'b0000011: w_cls = C_LOAD;
      7'b0100011: w_cls = C_STORE;
      7'b0010011: w_cls = C_OPIMM;
      7'b0110011: w_cls = C_OP;
      7'b0001111: w_cls = C_FENCE;
      default:    w_cls = C_ILL;
    endcase
  end

  // ALU operand/op and immediate format per class; held through EXEC, MEM and WB
  always_comb begin
    w_a_sel = 1'b0;
    w_b_sel = 1'b1;
    w_op    = 2'd0;
    w_fmt   = 3'd0;
    case (w_cls)
      C_LUI:    begin w_op = 2'd2; w_fmt = 3'd3; end
      C_AUIPC:  begin w_a_sel = 1'b1; w_fmt = 3'd3; end
      C_JAL:    begin w_a_sel = 1'b1; w_fmt = 3'd4; end
      C_BRANCH: begin w_a_sel = 1'b1; w_fmt = 3'd2; end
      C_STORE:  w_fmt = 3'd1;
      C_OPIMM:  w_op = 2'd1;
      C_OP:     begin w_op = 2'd1; w_b_sel = 1'b0; end
      C_JALR, C_LOAD: ;
      default:  begin w_b_sel = 1'b0; end
    endcase
  end

  // next-state and strobe decode; reset forces every output low
  always_comb begin
    w_next       = r_state;
    w_cause      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = 2'd0;
    imm_fmt      = 3'd0;
    trap         = r_trap;
    trap_cause   = r_trap_cause;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_cls == C_FENCE) begin
          pc_write = 1'b1;
          w_next   = S_FETCH;
        end else if (w_cls == C_ILL) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_a_sel = w_a_sel;
        alu_b_sel = w_b_sel;
        alu_op    = w_op;
        imm_fmt   = w_fmt;
        case (w_cls)
          C_LOAD, C_STORE: w_next = S_MEM;
          C_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
            w_next   = S_FETCH;
          end
          C_JAL, C_JALR: begin
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            w_next    = S_FETCH;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        alu_a_sel    = w_a_sel;
        alu_b_sel    = w_b_sel;
        alu_op       = w_op;
        imm_fmt      = w_fmt;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (w_cls == C_STORE);
        if (mem_ready) begin
          if (w_cls == C_STORE) begin
            pc_write = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 1'b1;
        end
      end
      S_WB: begin
        alu_a_sel = w_a_sel;
        alu_b_sel = w_b_sel;
        alu_op    = w_op;
        imm_fmt   = w_fmt;
        reg_write = 1'b1;
        wb_sel    = (w_cls == C_LOAD) ? 2'd1 : 2'd0;
        pc_write  = 1'b1;
        w_next    = S_FETCH;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write    = 1'b0;
      wb_sel       = 2'd0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      alu_op       = 2'd0;
      imm_fmt      = 3'd0;
      trap         = 1'b0;
      trap_cause   = 1'b0;
    end
  end

  // state, wait counter (cleared on every state change) and sticky trap flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_cnt        <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
        r_cnt <= w_cnt_inc[CW-1:0];
      end
      if (w_next == S_TRAP && r_state != S_TRAP) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_cause;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected strobe vectors
// are queued alongside the stimulus and compared as each cycle is applied.
module tb_multicycle_controller;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, branch_taken, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write;
  logic [1:0]  wb_sel, alu_op;
  logic        alu_a_sel, alu_b_sel, trap, trap_cause;
  logic [2:0]  imm_fmt;

  multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .imm_fmt(imm_fmt), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic [31:0] ins;
    logic        rdy;
    logic        tk;
  } stim_t;

  stim_t       stim_q[$];
  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %h expected %h", tag, n_vec, got, want);
    end
  endtask

  // {req,we,addr_sel,ir_write,pc_write,pc_src,reg_write,wb_sel,ctl[6:0],trap,cause}
  function automatic logic [17:0] v(bit req, bit we, bit asel, bit irw, bit pcw, bit pcs,
                                    bit rw, logic [1:0] wb, logic [6:0] c, bit tr, bit tc);
    return {req, we, asel, irw, pcw, pcs, rw, wb, c, tr, tc};
  endfunction

  // expected {alu_a_sel, alu_b_sel, alu_op, imm_fmt} by opcode
  function automatic logic [6:0] ctl(logic [6:0] op);
    case (op)
      7'b0110111: return {1'b0, 1'b1, 2'd2, 3'd3};
      7'b0010111: return {1'b1, 1'b1, 2'd0, 3'd3};
      7'b1101111: return {1'b1, 1'b1, 2'd0, 3'd4};
      7'b1100111: return {1'b0, 1'b1, 2'd0, 3'd0};
      7'b1100011: return {1'b1, 1'b1, 2'd0, 3'd2};
      7'b0000011: return {1'b0, 1'b1, 2'd0, 3'd0};
      7'b0100011: return {1'b0, 1'b1, 2'd0, 3'd1};
      7'b0010011: return {1'b0, 1'b1, 2'd1, 3'd0};
      7'b0110011: return {1'b0, 1'b0, 2'd1, 3'd0};
      default:    return 7'd0;
    endcase
  endfunction

  function automatic bit is_exec(logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endfunction

  task automatic push(string tag, bit r, logic [31:0] ins, bit rdy, bit tk, logic [17:0] e);
    stim_q.push_back('{r: r, ins: ins, rdy: rdy, tk: tk});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic gen_reset(int n);
    for (int i = 0; i < n; i++) push("reset", 1'b1, 32'h0, rnd(), 1'b0, 18'd0);
  endtask

  task automatic gen_trap(string tag, logic [31:0] ins, int n, bit cause);
    for (int i = 0; i < n; i++)
      push(tag, 1'b0, ins, rnd(), 1'b0, v(0,0,0,0,0,0,0,2'd0,7'd0,1'b1,cause));
  endtask

  // memory phase shared by fetch and data access; returns 1 if it timed out
  task automatic gen_mem(string tag, logic [31:0] ins, int w, bit tk, logic [17:0] waitv,
                         logic [17:0] donev, output bit timed_out);
    timed_out = (w >= TO);
    for (int i = 0; i < ((w >= TO) ? TO : w); i++) push(tag, 1'b0, ins, 1'b0, tk, waitv);
    if (timed_out) gen_trap(tag, ins, 3, 1'b1);
    else push(tag, 1'b0, ins, 1'b1, tk, donev);
  endtask

  task automatic gen_instr(string tag, logic [31:0] ins, int fw, int mw, bit tk);
    logic [6:0] op = ins[6:0];
    logic [6:0] c  = ctl(ins[6:0]);
    bit         to;
    gen_mem(tag, ins, fw, tk, v(1,0,0,0,0,0,0,2'd0,7'd0,0,0),
            v(1,0,0,1,0,0,0,2'd0,7'd0,0,0), to);
    if (to) return;
    if (op == 7'b0001111) begin
      push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,1,0,0,2'd0,7'd0,0,0));
      return;
    end
    push(tag, 1'b0, ins, rnd(), tk, 18'd0);
    if (!is_exec(op)) begin
      gen_trap(tag, ins, 3, 1'b0);
      return;
    end
    case (op)
      7'b0000011, 7'b0100011: begin
        bit st = (op == 7'b0100011);
        push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,0,0,0,2'd0,c,0,0));
        gen_mem(tag, ins, mw, tk, v(1,st,1,0,0,0,0,2'd0,c,0,0),
                v(1,st,1,0,st,0,0,2'd0,c,0,0), to);
        if (!to && !st) push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,1,0,1,2'd1,c,0,0));
      end
      7'b1100011: push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,1,tk,0,2'd0,c,0,0));
      7'b1101111, 7'b1100111:
        push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,1,1,1,2'd2,c,0,0));
      default: begin
        push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,0,0,0,2'd0,c,0,0));
        push(tag, 1'b0, ins, rnd(), tk, v(0,0,0,0,1,0,1,2'd0,c,0,0));
      end
    endcase
  endtask

  initial begin
    stim_t       s;
    logic [17:0] obs;
    logic [6:0]  c_lw;
    string       t;
    rst = 1'b1; instr = 32'h0; branch_taken = 1'b0; mem_ready = 1'b0;

    gen_reset(2);
    gen_instr("addi",      32'h00500093, 0, 0, 1'b0);
    gen_instr("lw_wait3",  32'h0000a103, 0, 3, 1'b0);
    gen_instr("sw_fwait3", 32'h0020a023, 3, 0, 1'b0);
    gen_instr("beq_t",     32'h00000463, 0, 0, 1'b1);
    gen_instr("beq_nt",    32'h00000463, 1, 0, 1'b0);
    gen_instr("jal",       32'h010000ef, 0, 0, 1'b0);
    gen_instr("jalr",      32'h000080e7, 0, 0, 1'b1);
    gen_instr("lui",       32'h123450b7, 0, 0, 1'b0);
    gen_instr("auipc",     32'h00001097, 2, 0, 1'b0);
    gen_instr("add",       32'h002081b3, 0, 0, 1'b0);
    gen_instr("fence",     32'h0000000f, 0, 0, 1'b0);
    gen_instr("sw_mwait2", 32'h0020a023, 0, 2, 1'b0);

    // reset in the middle of a load's memory wait
    c_lw = ctl(7'b0000011);
    push("rst_mid", 1'b0, 32'h0000a103, 1'b1, 1'b0, v(1,0,0,1,0,0,0,2'd0,7'd0,0,0));
    push("rst_mid", 1'b0, 32'h0000a103, 1'b0, 1'b0, 18'd0);
    push("rst_mid", 1'b0, 32'h0000a103, 1'b0, 1'b0, v(0,0,0,0,0,0,0,2'd0,c_lw,0,0));
    push("rst_mid", 1'b0, 32'h0000a103, 1'b0, 1'b0, v(1,0,1,0,0,0,0,2'd0,c_lw,0,0));
    gen_reset(1);
    gen_instr("post_rst",  32'h00500093, 0, 0, 1'b0);

    gen_instr("illegal",   32'hffffffff, 0, 0, 1'b0);
    gen_reset(1);
    gen_instr("system",    32'h00000073, 0, 0, 1'b0);
    gen_reset(1);
    gen_instr("mem_to",    32'h0000a103, 0, 4, 1'b0);
    gen_reset(1);
    gen_instr("fetch_to",  32'h00500093, 6, 0, 1'b0);
    gen_reset(1);
    gen_instr("final",     32'h002081b3, 0, 0, 1'b0);

    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      t = tag_q.pop_front();
      @(posedge clk);
      #1;
      rst = s.r; instr = s.ins; mem_ready = s.rdy; branch_taken = s.tk;
      @(negedge clk);
      obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write,
             wb_sel, alu_a_sel, alu_b_sel, alu_op, imm_fmt, trap, trap_cause};
      chk(t, obs, exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
